// File: rtl/sccb_target.sv
// SCCB target bridging ID/address/data phases to a register file; define SCCB_TARGET_ACK_EN to drive ACK.
// Latency: inputs pass a 2-flop synchronizer and a FILT_CYCLES filter; read data is driven 2 cycles after a filtered sio_c fall.
// Backpressure: none; the register file must accept rf_wr/rf_rd strobes and return rf_rdata one cycle after rf_rd.
module sccb_target #(
    parameter int FILT_CYCLES = 3
) (
    input  logic       sccb_clk,
    input  logic       sccb_reset_n,
    input  logic [6:0] dev_id,
    input  logic       sio_c,
    input  logic       sio_d_i,
    output logic       sio_d_o,
    output logic       sio_d_oe,
    output logic       rf_wr,
    output logic       rf_rd,
    output logic [7:0] rf_addr,
    output logic [7:0] rf_wdata,
    input  logic [7:0] rf_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_WDATA, S_RDATA, S_IGNORE} state_t;

    // index 1 = sio_c, index 0 = sio_d
    logic [1:0] raw, sync1, sync2, filt, filt_q;
    logic [3:0] fcnt [2];

    assign raw = {sio_c, sio_d_i};

    always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
        if (!sccb_reset_n) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= 4'd0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= 4'd0;
                end else if (fcnt[i] == 4'(FILT_CYCLES - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= 4'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    logic c_rise, c_fall, start_det, stop_det;
    assign c_rise    = filt[1] & ~filt_q[1];
    assign c_fall    = ~filt[1] & filt_q[1];
    assign start_det = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
    assign stop_det  = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] sr, addr, tx;
    logic [7:0] byte_nxt;
    logic       id_match;

    assign byte_nxt = {sr[6:0], filt[0]};
    assign id_match = (sr[7:1] == dev_id);

    always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
        if (!sccb_reset_n) begin
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            sr       <= 8'h00;
            addr     <= 8'h00;
            tx       <= 8'h00;
            sio_d_o  <= 1'b1;
            sio_d_oe <= 1'b0;
            rf_wr    <= 1'b0;
            rf_rd    <= 1'b0;
            rf_addr  <= 8'h00;
            rf_wdata <= 8'h00;
            busy     <= 1'b0;
        end else begin
            rf_wr <= 1'b0;
            rf_rd <= 1'b0;
            if (start_det) begin
                state    <= S_ID;
                bit_cnt  <= 4'd0;
                busy     <= 1'b1;
                sio_d_oe <= 1'b0;
                sio_d_o  <= 1'b1;
            end else if (stop_det) begin
                state    <= S_IDLE;
                bit_cnt  <= 4'd0;
                busy     <= 1'b0;
                sio_d_oe <= 1'b0;
                sio_d_o  <= 1'b1;
            end else if (rf_rd && state == S_RDATA) begin
                // read data arrives one cycle after the strobe; MSB goes straight to the pad
                tx       <= rf_rdata;
                sio_d_o  <= rf_rdata[7];
                sio_d_oe <= 1'b1;
            end else if (c_rise && state != S_IDLE) begin
                if (bit_cnt != 4'd8) begin
                    sr      <= byte_nxt;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        case (state)
                            S_ADDR: addr <= byte_nxt;
                            S_WDATA: begin
                                rf_wr    <= 1'b1;
                                rf_addr  <= addr;
                                rf_wdata <= byte_nxt;
                                addr     <= addr + 8'd1;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    // 9th bit: phase transitions happen here
                    bit_cnt <= 4'd0;
                    case (state)
                        S_ID:    state <= !id_match ? S_IGNORE : (sr[0] ? S_RDATA : S_ADDR);
                        S_ADDR:  state <= S_WDATA;
                        S_RDATA: addr  <= addr + 8'd1;
                        default: ;
                    endcase
                end
            end else if (c_fall) begin
                case (state)
`ifdef SCCB_TARGET_ACK_EN
                    S_ID, S_ADDR, S_WDATA: begin
                        if (bit_cnt == 4'd8 && (state != S_ID || id_match)) begin
                            sio_d_oe <= 1'b1;
                            sio_d_o  <= 1'b0;
                        end else begin
                            sio_d_oe <= 1'b0;
                            sio_d_o  <= 1'b1;
                        end
                    end
`endif
                    S_RDATA: begin
                        if (bit_cnt == 4'd0) begin
                            rf_rd    <= 1'b1;
                            rf_addr  <= addr;
                            sio_d_oe <= 1'b0;
                            sio_d_o  <= 1'b1;
                        end else if (bit_cnt == 4'd8) begin
                            sio_d_oe <= 1'b0;
                            sio_d_o  <= 1'b1;
                        end else begin
                            sio_d_o <= tx[3'd7 - bit_cnt[2:0]];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: SCCB initiator model, register-file model and write/read scoreboards.
module tb_sccb_target;

    localparam int H = 12;

    logic       sccb_clk = 1'b0;
    logic       sccb_reset_n = 1'b0;
    logic [6:0] dev_id = 7'h21;
    logic       sio_c = 1'b1;
    logic       m_d = 1'b1;
    logic       sio_d_i;
    logic       sio_d_o, sio_d_oe, rf_wr, rf_rd, busy;
    logic [7:0] rf_addr, rf_wdata, rf_rdata;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    int oe_cycles = 0;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];

    // open-drain bus: either side pulls low
    assign sio_d_i  = m_d & (sio_d_oe ? sio_d_o : 1'b1);
    assign rf_rdata = mem[rf_addr];

    always #5 sccb_clk = ~sccb_clk;

    sccb_target #(.FILT_CYCLES(3)) dut (
        .sccb_clk     (sccb_clk),
        .sccb_reset_n (sccb_reset_n),
        .dev_id       (dev_id),
        .sio_c        (sio_c),
        .sio_d_i      (sio_d_i),
        .sio_d_o      (sio_d_o),
        .sio_d_oe     (sio_d_oe),
        .rf_wr        (rf_wr),
        .rf_rd        (rf_rd),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .rf_rdata     (rf_rdata),
        .busy         (busy)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge sccb_clk);
        #1;
    endtask

    task automatic bus_start();
        if (sio_c == 1'b0) begin
            m_d = 1'b1;
            cyc(8);
            sio_c = 1'b1;
            cyc(H);
        end
        m_d = 1'b0;
        cyc(H);
        sio_c = 1'b0;
        cyc(4);
    endtask

    task automatic bus_stop();
        m_d = 1'b0;
        cyc(8);
        sio_c = 1'b1;
        cyc(H);
        m_d = 1'b1;
        cyc(H);
    endtask

    // entered 4 cycles into sio_c low; samples pad and drive state mid-high
    task automatic send_bit(input logic b, output logic pad, output logic oe, output logic o);
        m_d = b;
        cyc(8);
        sio_c = 1'b1;
        cyc(H / 2);
        pad = sio_d_i;
        oe  = sio_d_oe;
        o   = sio_d_o;
        cyc(H / 2);
        sio_c = 1'b0;
        cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        logic p, oe, o;
        logic [1:0] exp;
        for (int i = 7; i >= 0; i--) send_bit(b[i], p, oe, o);
        send_bit(1'b1, p, oe, o);
`ifdef SCCB_TARGET_ACK_EN
        exp = exp_ack ? 2'b10 : 2'b01;
`else
        exp = 2'b01;
`endif
        checks++;
        if ({oe, o} !== exp) begin
            errors++;
            $display("FAIL ack_bit byte=%h oe_o=%b expected=%b", b, {oe, o}, exp);
        end
    endtask

    task automatic read_byte(output logic [7:0] got, input logic nack);
        logic p, oe, o;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, p, oe, o);
            got = {got[6:0], p};
        end
        send_bit(nack, p, oe, o);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained wr_left=%0d rd_left=%0d expected 0 0", name, wr_q.size(), rd_q.size());
        end
    endtask

    task automatic check_busy(input string name, input logic exp);
        checks++;
        if (busy !== exp) begin
            errors++;
            $display("FAIL %s_busy got=%b expected=%b", name, busy, exp);
        end
    endtask

    task automatic test_reset();
        logic [20:0] got;
        cyc(3);
        got = {sio_d_oe, sio_d_o, rf_wr, rf_rd, rf_addr, rf_wdata, busy};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got=%h expected=%h", got, 21'h080000);
        end
        sccb_reset_n = 1'b1;
        cyc(10);
    endtask

    task automatic test_write();
        wr_q.push_back({8'h12, 8'h80});
        bus_start();
        check_busy("write_start", 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h80, 1'b1);
        bus_stop();
        check_busy("write_stop", 1'b0);
        check_drained("write");
    endtask

    task automatic test_read();
        logic [7:0] got;
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'h0A, 1'b1);
        bus_stop();
        rd_q.push_back(8'h0A);
        rd_q.push_back(8'h0B);
        bus_start();
        send_byte(8'h43, 1'b1);
        read_byte(got, 1'b1);
        bus_stop();
        checks++;
        if (got !== 8'h76) begin
            errors++;
            $display("FAIL read_data got=%h expected=%h", got, 8'h76);
        end
        check_busy("read_stop", 1'b0);
        check_drained("read");
    endtask

    task automatic test_ignore();
        oe_cycles = 0;
        bus_start();
        send_byte(8'h60, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h55, 1'b0);
        bus_stop();
        checks++;
        if (oe_cycles != 0) begin
            errors++;
            $display("FAIL ignore_oe cycles_driven=%0d expected=0", oe_cycles);
        end
        check_drained("ignore");
    endtask

    task automatic test_back_to_back();
        wr_q.push_back({8'h12, 8'hAA});
        wr_q.push_back({8'h13, 8'hBB});
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        bus_stop();
        check_drained("b2b");
    endtask

    task automatic test_partial();
        logic p, oe, o;
        logic [7:0] got;
        logic [3:0] nib;
        nib = 4'b1010;
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'h20, 1'b1);
        for (int i = 3; i >= 0; i--) send_bit(nib[i], p, oe, o);
        bus_stop();
        check_busy("partial_stop", 1'b0);
        rd_q.push_back(8'h20);
        rd_q.push_back(8'h21);
        bus_start();
        send_byte(8'h43, 1'b1);
        read_byte(got, 1'b1);
        bus_stop();
        checks++;
        if (got !== 8'h5C) begin
            errors++;
            $display("FAIL partial_read got=%h expected=%h", got, 8'h5C);
        end
        check_drained("partial");
    endtask

    task automatic test_reset_mid_read();
        logic p, oe, o;
        logic [7:0] got;
        rd_q.push_back(8'h21);
        bus_start();
        send_byte(8'h43, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, p, oe, o);
        m_d = 1'b1;
        cyc(8);
        sio_c = 1'b1;
        cyc(H / 2);
        checks++;
        if (sio_d_oe !== 1'b1) begin
            errors++;
            $display("FAIL midread_drive oe=%b expected=1", sio_d_oe);
        end
        #2;
        sccb_reset_n = 1'b0;
        #1;
        checks++;
        if ({sio_d_oe, sio_d_o} !== 2'b01) begin
            errors++;
            $display("FAIL async_release oe_o=%b expected=01", {sio_d_oe, sio_d_o});
        end
        cyc(3);
        sccb_reset_n = 1'b1;
        cyc(10);
        check_busy("after_reset", 1'b0);
        check_drained("midread");
        // address was reset, so a fresh read starts at 0
        rd_q.push_back(8'h00);
        rd_q.push_back(8'h01);
        bus_start();
        send_byte(8'h43, 1'b1);
        read_byte(got, 1'b1);
        bus_stop();
        checks++;
        if (got !== 8'hE1) begin
            errors++;
            $display("FAIL post_reset_read got=%h expected=%h", got, 8'hE1);
        end
        check_drained("post_reset");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        mem[8'h0A] = 8'h76;
        mem[8'h20] = 8'h5C;
        mem[8'h00] = 8'hE1;

        fork
            forever begin
                logic [15:0] e;
                logic [7:0]  ra;
                @(negedge sccb_clk);
                if (sio_d_oe) oe_cycles++;
                if (rf_wr && rf_rd) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_rd_overlap wr=%b rd=%b expected not both", rf_wr, rf_rd);
                end
                if (rf_wr) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_wr addr=%h data=%h expected no write", rf_addr, rf_wdata);
                    end else begin
                        e = wr_q.pop_front();
                        if ({rf_addr, rf_wdata} !== e) begin
                            errors++;
                            $display("FAIL wr_pulse addr_data=%h expected=%h", {rf_addr, rf_wdata}, e);
                        end
                    end
                end
                if (rf_rd) begin
                    checks++;
                    if (rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rd addr=%h expected no read", rf_addr);
                    end else begin
                        ra = rd_q.pop_front();
                        if (rf_addr !== ra) begin
                            errors++;
                            $display("FAIL rd_pulse addr=%h expected=%h", rf_addr, ra);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_write();
        test_read();
        test_ignore();
        test_back_to_back();
        test_partial();
        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter FILT_CYCLES, default 3: number of consecutive equal sccb_clk samples required before a filtered sio_c/sio_d level changes (range 1..15).
REQ-002 SHALL have port sccb_clk, in, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port sccb_reset_n, in, 1: asynchronous, active-low reset.
REQ-004 SHALL have port dev_id, in, 7: 7-bit device ID matched against ID byte bits [7:1].
REQ-005 SHALL have port sio_c, in, 1: SCCB clock from the initiator.
REQ-006 SHALL have port sio_d_i, in, 1: SCCB data pad input.
REQ-007 SHALL have ports sio_d_o, out, 1, and sio_d_oe, out, 1: data drive value and enable; the top level builds the tristate.
REQ-008 SHALL have ports rf_wr, out, 1; rf_rd, out, 1; rf_addr, out, 8; rf_wdata, out, 8: register-file write/read strobes, address and write data.
REQ-009 SHALL have port rf_rdata, in, 8: register read data, sampled exactly 1 cycle after rf_rd.
REQ-010 SHALL have port busy, out, 1: high from a detected start to the following stop.

Function
REQ-011 Inputs: 2-flop synchronizer then FILT_CYCLES filter; edges and start/stop detection use the filtered levels only.
REQ-012 Start = filtered sio_d falling while sio_c high; stop = filtered sio_d rising while sio_c high; data is sampled on filtered sio_c rising edges.
REQ-013 States: IDLE, ID, ADDR, WDATA, RDATA, IGNORE; a 4-bit bit counter counts 0..8 per 9-bit phase.
REQ-014 A start in any state (repeated start included) SHALL clear the bit counter and enter ID; a stop in any state SHALL enter IDLE and release sio_d.
REQ-015 ID phase: after 8 bits, on a match of bits [7:1] with dev_id, go to ADDR if bit0=0, or to RDATA if bit0=1; on a mismatch, go to IGNORE.
REQ-016 ADDR phase: after 8 bits, the internal address register (8 bits) SHALL load the byte; the next phase is WDATA.
REQ-017 WDATA phase: after 8 bits, rf_wr SHALL pulse 1 cycle with rf_addr=address and rf_wdata=byte; the address then increments mod 256, and WDATA repeats for further bytes.
REQ-018 RDATA phase: on the sio_c falling edge that ends the ID 9th bit, rf_rd SHALL pulse 1 cycle and rf_rdata SHALL be captured the next cycle; the byte is driven MSB first, each bit changing within 2 cycles after a filtered sio_c fall; sio_d is released during the 9th bit, then the address increments and the next byte is fetched.
REQ-019 When driving, sio_d_o SHALL equal the data bit and sio_d_oe=1; otherwise sio_d_oe=0 and sio_d_o=1.
REQ-020 The address register SHALL persist across transactions, so a 2-phase write (ID, addr, stop) followed by a 2-phase read reads that address.
REQ-021 A partial byte ended by a start or stop SHALL be discarded, with no rf_wr and no address change.
REQ-022 Correct operation requires sio_c high and low times of at least FILT_CYCLES+4 sccb_clk cycles.
REQ-023 rf_wr and rf_rd SHALL never be asserted in the same cycle.

Reset
REQ-024 On reset: state IDLE, bit counter 0, address 0, sio_d_oe=0, sio_d_o=1, rf_wr=0, rf_rd=0, rf_addr=0, rf_wdata=0, busy=0; filter flops set to 1 (bus idle).
REQ-025 Reset asserted mid-transaction SHALL release sio_d immediately (asynchronously); after release, the block waits for a new start.

Configuration
REQ-026 Macro SCCB_TARGET_ACK_EN defined: during the 9th bit of a matched ID (write or read), ADDR and WDATA phases, the block SHALL drive sio_d low (ACK), from the sio_c fall after bit 8 until the next sio_c fall.
REQ-027 Macro SCCB_TARGET_ACK_EN undefined: the 9th bit is don't-care and sio_d_oe stays 0 throughout it.

Verification
REQ-028 dev_id=7'h21; send start, 0x42, 0x12, 0x80, stop -> one rf_wr pulse with rf_addr=0x12, rf_wdata=0x80; busy falls after stop.
REQ-029 Send start, 0x42, 0x0A, stop, then start, 0x43, with rf_rdata=0x76, then stop -> rf_rd pulses with rf_addr=0x0A, and sio_d carries 0,1,1,1,0,1,1,0.
REQ-030 Send start, 0x60, 0x12, 0x55, stop -> no rf_wr or rf_rd, sio_d_oe=0 throughout.
REQ-031 Send start, 0x42, 0x12, 0xAA, 0xBB, stop -> two rf_wr pulses: (0x12,0xAA) then (0x13,0xBB); with SCCB_TARGET_ACK_EN, sio_d is low in each 9th bit.
REQ-032 Send a stop after 4 bits of WDATA -> no rf_wr, state IDLE; assert sccb_reset_n low during RDATA bit 3 -> sio_d_oe=0 in the same cycle.
